// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command encodings, refresh FSM states and default timing constants
package sdram_pkg;
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;
  localparam logic [3:0] CMD_MODE_REG  = 4'b0000;
  localparam int DEF_REF_INTERVAL = 750;
  localparam int DEF_TRP_CYCLES   = 2;
  localparam int DEF_TRFC_CYCLES  = 7;
  localparam int DEF_AREF_BURST   = 2;
  typedef enum logic [2:0] {
    AREF_IDLE,
    AREF_PCH,
    AREF_WAIT_TRP,
    AREF_AREF,
    AREF_WAIT_TRFC,
    AREF_END
  } aref_state_t;
endpackage

// File: rtl/sdram_wait_counter.sv
// sdram_wait_counter: 3-bit saturating cycle counter with clear/enable, used for tRP and tRFC waits
module sdram_wait_counter (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       clear,
  input  logic       enable,
  output logic [2:0] count
);
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (enable && count != 3'd7) count <= count + 3'd1;
endmodule

// File: rtl/sdram_auto_refresh.sv
// sdram_auto_refresh: periodic PRECHARGE-all + AUTO_REFRESH burst generator gated by init_done.
// Define SDRAM_AREF_LATE_EN to add the aref_late_cnt port counting refreshes requested while one was still pending.
module sdram_auto_refresh
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = DEF_REF_INTERVAL,
  parameter int TRP_CYCLES   = DEF_TRP_CYCLES,
  parameter int TRFC_CYCLES  = DEF_TRFC_CYCLES,
  parameter int AREF_BURST   = DEF_AREF_BURST
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_done,
  input  logic        aref_en,
  output logic        aref_req,
  output logic [3:0]  aref_cmd,
  output logic [1:0]  aref_bank,
  output logic [11:0] aref_addr,
  output logic        aref_end
`ifdef SDRAM_AREF_LATE_EN
  ,
  output logic [7:0]  aref_late_cnt
`endif
);
  localparam int IW = $clog2(REF_INTERVAL);
  aref_state_t state;
  logic [IW-1:0] int_cnt;
  logic [2:0] wait_cnt;
  logic [2:0] ref_cnt;
  logic wrap;
  logic accept;
  assign wrap = init_done && int_cnt == IW'(REF_INTERVAL - 1);
  assign accept = init_done && state == AREF_IDLE && aref_req && aref_en;
  assign aref_bank = 2'b11;
  assign aref_addr = 12'hfff;
  sdram_wait_counter u_wait (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (state == AREF_PCH || state == AREF_AREF),
    .enable    (state == AREF_WAIT_TRP || state == AREF_WAIT_TRFC),
    .count     (wait_cnt)
  );
  // A wrap coinciding with acceptance re-arms the request rather than losing it
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      int_cnt  <= '0;
      aref_req <= 1'b0;
    end else if (!init_done) begin
      int_cnt  <= '0;
      aref_req <= 1'b0;
    end else begin
      int_cnt  <= wrap ? '0 : int_cnt + IW'(1);
      aref_req <= wrap | (aref_req & ~accept);
    end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state    <= AREF_IDLE;
      ref_cnt  <= '0;
      aref_cmd <= CMD_NOP;
      aref_end <= 1'b0;
    end else if (!init_done) begin
      state    <= AREF_IDLE;
      ref_cnt  <= '0;
      aref_cmd <= CMD_NOP;
      aref_end <= 1'b0;
    end else begin
      aref_cmd <= state == AREF_PCH ? CMD_PRECHARGE : state == AREF_AREF ? CMD_AUTO_REF : CMD_NOP;
      aref_end <= state == AREF_END;
      case (state)
        AREF_IDLE: begin
          ref_cnt <= '0;
          if (accept) state <= AREF_PCH;
        end
        AREF_PCH:      state <= AREF_WAIT_TRP;
        AREF_WAIT_TRP: if (wait_cnt == 3'(TRP_CYCLES)) state <= AREF_AREF;
        AREF_AREF:     state <= AREF_WAIT_TRFC;
        AREF_WAIT_TRFC:
          if (wait_cnt == 3'(TRFC_CYCLES)) begin
            if (ref_cnt < 3'(AREF_BURST - 1)) begin
              ref_cnt <= ref_cnt + 3'd1;
              state   <= AREF_AREF;
            end else state <= AREF_END;
          end
        AREF_END: state <= AREF_IDLE;
        default:  state <= AREF_IDLE;
      endcase
    end
`ifdef SDRAM_AREF_LATE_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) aref_late_cnt <= '0;
    else if (wrap && aref_req && !accept && aref_late_cnt != 8'hff) aref_late_cnt <= aref_late_cnt + 8'd1;
`endif
endmodule
